// File: rtl/rotator_arbiter_if.sv
// Request, rotator and response signals of the shared right-rotator scheduler.
// The slave modport is the arbiter; the master modport is requesters, rotator and consumer.
// Widths are set by the instantiating parent and must match the arbiter's parameters.
interface rotator_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATAWIDTH = 32,
  parameter int ROTBITS   = 5,
  parameter int IDBITS    = 2
);
  logic [NUM_REQ-1:0]           reqValid;
  logic [NUM_REQ-1:0]           reqReady;
  logic [NUM_REQ*DATAWIDTH-1:0] reqData;
  logic [NUM_REQ*ROTBITS-1:0]   reqRotation;
  logic [DATAWIDTH-1:0]         rotDataIn;
  logic [ROTBITS-1:0]           rotRotation;
  logic [DATAWIDTH-1:0]         rotDataOut;
  logic                         respValid;
  logic                         respReady;
  logic [DATAWIDTH-1:0]         respData;
  logic [IDBITS-1:0]            respId;
  logic                         busy;

  modport slave (
    input  reqValid, reqData, reqRotation, rotDataOut, respReady,
    output reqReady, rotDataIn, rotRotation, respValid, respData, respId, busy
  );

  modport master (
    output reqValid, reqData, reqRotation, rotDataOut, respReady,
    input  reqReady, rotDataIn, rotRotation, respValid, respData, respId, busy
  );
endinterface

// File: rtl/rotator_arbiter.sv
// Round-robin scheduler sharing one right-rotator among NUM_REQ requesters, results in an ordered FIFO.
// Latency: issue at T -> FIFO write end of T+ROT_LATENCY -> respValid at T+ROT_LATENCY+1.
// Backpressure: credit-based issue (a same-cycle pop frees a credit); respData/respId held while stalled.
// Optional stats counters (grantCount, stallCount) are enabled by defining ROTATOR_ARB_STATS_EN.
module rotator_arbiter #(
  parameter int NUM_REQ            = 4,
  parameter int DATAWIDTH          = 32,
  parameter int SHIFTBITS_PER_STEP = 1,
  parameter int ROT_LATENCY        = 0,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rotator_arbiter_if.slave  bus
`ifdef ROTATOR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0] grantCount,
  output logic [15:0]           stallCount
`endif
);
  localparam int ROTBITS = $clog2(DATAWIDTH / SHIFTBITS_PER_STEP);
  localparam int IDBITS  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTRBITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTBITS = $clog2(FIFO_DEPTH + 1);

  logic [IDBITS-1:0]    lastGrant;
  logic [IDBITS-1:0]    grantId;
  logic [IDBITS-1:0]    cand;
  logic                 found;
  logic                 anyValid;
  logic                 creditOk;
  logic                 issue;
  logic                 pop;
  logic                 push;
  logic                 respValidC;
  int                   inFlight;
  logic                 finalValid;
  logic [IDBITS-1:0]    finalId;

  logic [NUM_REQ-1:0]   reqReadyC;
  logic [DATAWIDTH-1:0] rotDataInC;
  logic [ROTBITS-1:0]   rotRotationC;

  logic [DATAWIDTH-1:0] memData [FIFO_DEPTH];
  logic [IDBITS-1:0]    memId   [FIFO_DEPTH];
  logic [PTRBITS-1:0]   rdPtr, wrPtr, rdNext;
  logic [CNTBITS-1:0]   fifoCount;
  logic [DATAWIDTH-1:0] respDataQ, headDataNext;
  logic [IDBITS-1:0]    respIdQ, headIdNext;

  function automatic logic [PTRBITS-1:0] ptrInc(input logic [PTRBITS-1:0] p);
    if (int'(p) == FIFO_DEPTH - 1) return '0;
    return p + 1'b1;
  endfunction

  // Round-robin search starting just after the last granted requester
  always_comb begin
    anyValid = |bus.reqValid;
    grantId  = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDBITS'((int'(lastGrant) + k) % NUM_REQ);
      if (!found && bus.reqValid[cand]) begin
        found   = 1'b1;
        grantId = cand;
      end
    end
  end

  // Credits: free FIFO slots minus results still in the rotator, plus a same-cycle pop
  always_comb begin
    respValidC = (fifoCount != '0);
    pop        = respValidC & bus.respReady;
    creditOk   = (int'(fifoCount) + inFlight) < (FIFO_DEPTH + int'(pop));
    issue      = rst_n & anyValid & creditOk;
  end

  // Grant handshake and rotator drive; rotator inputs are zero when nothing issues
  always_comb begin
    reqReadyC    = '0;
    rotDataInC   = '0;
    rotRotationC = '0;
    if (issue) begin
      reqReadyC[grantId] = 1'b1;
      rotDataInC         = bus.reqData[grantId*DATAWIDTH +: DATAWIDTH];
      rotRotationC       = bus.reqRotation[grantId*ROTBITS +: ROTBITS];
    end
  end

  // Remember the winner so the next search starts after it
  always_ff @(posedge clk) begin
    if (!rst_n) lastGrant <= IDBITS'(NUM_REQ - 1);
    else if (issue) lastGrant <= grantId;
  end

  generate
    if (ROT_LATENCY == 0) begin : gNoLat
      assign finalValid = issue;
      assign finalId    = grantId;
      assign inFlight   = 0;
    end else begin : gLat
      logic [ROT_LATENCY-1:0]             tagValid;
      logic [ROT_LATENCY-1:0][IDBITS-1:0] tagId;

      // Carry requester ids alongside the rotator's internal pipeline
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          tagValid <= '0;
          tagId    <= '0;
        end else begin
          tagValid[0] <= issue;
          tagId[0]    <= grantId;
          for (int i = 1; i < ROT_LATENCY; i++) begin
            tagValid[i] <= tagValid[i-1];
            tagId[i]    <= tagId[i-1];
          end
        end
      end

      assign finalValid = tagValid[ROT_LATENCY-1];
      assign finalId    = tagId[ROT_LATENCY-1];

      // Number of results that will still land in the FIFO
      always_comb begin
        inFlight = 0;
        for (int i = 0; i < ROT_LATENCY; i++) inFlight += int'(tagValid[i]);
      end
    end
  endgenerate

  assign push   = finalValid;
  assign rdNext = ptrInc(rdPtr);

  // Next head register value; the pushed entry bypasses storage when the FIFO drains to it
  always_comb begin
    headDataNext = respDataQ;
    headIdNext   = respIdQ;
    if (pop) begin
      if (fifoCount > CNTBITS'(1)) begin
        headDataNext = memData[rdNext];
        headIdNext   = memId[rdNext];
      end else if (push) begin
        headDataNext = bus.rotDataOut;
        headIdNext   = finalId;
      end
    end else if (!respValidC && push) begin
      headDataNext = bus.rotDataOut;
      headIdNext   = finalId;
    end
  end

  // FIFO storage; contents are don't-care until counted as valid
  always_ff @(posedge clk) begin
    if (push) begin
      memData[wrPtr] <= bus.rotDataOut;
      memId[wrPtr]   <= finalId;
    end
  end

  // FIFO pointers, occupancy and registered head outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      fifoCount <= '0;
      respDataQ <= '0;
      respIdQ   <= '0;
    end else begin
      if (push) wrPtr <= ptrInc(wrPtr);
      if (pop)  rdPtr <= rdNext;
      case ({push, pop})
        2'b10:   fifoCount <= fifoCount + 1'b1;
        2'b01:   fifoCount <= fifoCount - 1'b1;
        default: fifoCount <= fifoCount;
      endcase
      respDataQ <= headDataNext;
      respIdQ   <= headIdNext;
    end
  end

`ifdef ROTATOR_ARB_STATS_EN
  // Saturating per-requester issue counts and credit-stall cycle count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grantCount <= '0;
      stallCount <= '0;
    end else begin
      if (issue && grantCount[grantId*16 +: 16] != 16'hFFFF)
        grantCount[grantId*16 +: 16] <= grantCount[grantId*16 +: 16] + 16'd1;
      if (anyValid && !creditOk && stallCount != 16'hFFFF)
        stallCount <= stallCount + 16'd1;
    end
  end
`endif

  assign bus.reqReady    = reqReadyC;
  assign bus.rotDataIn   = rotDataInC;
  assign bus.rotRotation = rotRotationC;
  assign bus.respValid   = respValidC;
  assign bus.respData    = respDataQ;
  assign bus.respId      = respIdQ;
  assign bus.busy        = respValidC | (inFlight != 0);
endmodule
